// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: holds the PC, issues one fetch at a time to instruction
// memory and presents the fetched word to decode until decode consumes it.
module ysyx_23060332_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        idu_ready_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i
);

    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic        inst_valid_q, inst_valid_d;
    logic        fire;

    assign fire = inst_valid_q && idu_ready_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_addr_d  = inst_addr_q;
        inst_valid_d = inst_valid_q;
        case (state_q)
            S_RESET: state_d = S_REQ;
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    inst_d       = imem_resp_data;
                    inst_addr_d  = pc_q;
                    inst_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                // Redirect or sequential advance only when decode actually takes the instruction.
                if (fire) begin
                    pc_d         = jump_flag_i ? (jump_addr_i & 32'hFFFF_FFFC) : (pc_q + 32'd4);
                    inst_valid_d = 1'b0;
                    inst_d       = NOP_INST;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RESET;
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            inst_addr_q  <= RESET_PC;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_addr_q  <= inst_addr_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid_o   = inst_valid_q;
    assign inst_o         = inst_q;
    assign inst_addr_o    = inst_addr_q;

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Self-checking bench for the fetch unit: a directed vector table, hand-built
// corner sequences, then randomized memory/decode behaviour against a transaction model.
module tb_ysyx_23060332_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        idu_ready_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ysyx_23060332_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .inst_valid_o   (inst_valid_o),
        .inst_o         (inst_o),
        .inst_addr_o    (inst_addr_o),
        .idu_ready_i    (idu_ready_i),
        .jump_flag_i    (jump_flag_i),
        .jump_addr_i    (jump_addr_i)
    );

    typedef struct {
        logic        rr;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        jf;
        logic [31:0] ja;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_iaddr;
    } vec_t;

    vec_t vecs[20];

    // Drive one cycle of inputs, let the edge happen, and return 1 time unit later.
    task automatic applyStimulus(input logic rr, input logic rv, input logic [31:0] rd,
                                 input logic ir, input logic jf, input logic [31:0] ja);
        imem_req_ready  = rr;
        imem_resp_valid = rv;
        imem_resp_data  = rd;
        idu_ready_i     = ir;
        jump_flag_i     = jf;
        jump_addr_i     = ja;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        checkOutput({tag, "_req_addr"}, imem_req_addr, RESET_PC);
        checkOutput({tag, "_inst_valid"}, 32'(inst_valid_o), 32'd0);
        checkOutput({tag, "_inst"}, inst_o, NOP);
        checkOutput({tag, "_inst_addr"}, inst_addr_o, RESET_PC);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic doReset();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        idu_ready_i     = 1'b0;
        jump_flag_i     = 1'b0;
        jump_addr_i     = 32'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("rst_hold");
        rst = 1'b0;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    initial begin
        logic [31:0] held_inst;
        logic [31:0] held_addr;
        logic        exp_req;
        logic        exp_valid;
        logic        pend;
        logic        nreq;
        logic        nvalid;
        logic [31:0] mpc;
        logic [31:0] exp_inst;
        logic [31:0] exp_ia;
        logic        rr;
        logic        rv;
        logic        ir;
        logic        jf;
        logic [31:0] rd;
        logic [31:0] ja;
        int          wcnt;

        // rr rv rd ir jf ja | req addr valid inst iaddr
        vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0000, 1'b0, NOP,           32'h0};
        vecs[1]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,         1'b0, 32'h8000_0000, 1'b0, NOP,           32'h0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0010_0093, 1'b0, 1'b0, 32'h0,         1'b0, 32'h8000_0000, 1'b1, 32'h0010_0093, 32'h8000_0000};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0004, 1'b0, NOP,           32'h0};
        vecs[4]  = '{1'b1, 1'b1, 32'hBAD0_0001, 1'b0, 1'b0, 32'h0,         1'b0, 32'h8000_0004, 1'b0, NOP,           32'h0};
        vecs[5]  = '{1'b0, 1'b1, 32'h0020_0113, 1'b0, 1'b0, 32'h0,         1'b0, 32'h8000_0004, 1'b1, 32'h0020_0113, 32'h8000_0004};
        vecs[6]  = '{1'b1, 1'b1, 32'hBAD0_0002, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h8000_0004, 1'b1, 32'h0020_0113, 32'h8000_0004};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0103, 1'b1, 32'h8000_0100, 1'b0, NOP,           32'h0};
        vecs[8]  = '{1'b0, 1'b1, 32'hBAD0_0003, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0100, 1'b0, NOP,           32'h0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h8000_0100, 1'b0, NOP,           32'h0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h8000_0100, 1'b0, NOP,           32'h0};
        vecs[11] = '{1'b0, 1'b1, 32'h0030_0193, 1'b0, 1'b0, 32'h0,         1'b0, 32'h8000_0100, 1'b1, 32'h0030_0193, 32'h8000_0100};
        vecs[12] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h9000_0000, 1'b0, 32'h8000_0100, 1'b1, 32'h0030_0193, 32'h8000_0100};
        vecs[13] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h9000_0000, 1'b1, 32'h8000_0104, 1'b0, NOP,           32'h0};
        vecs[14] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h8000_0104, 1'b0, NOP,           32'h0};
        vecs[15] = '{1'b0, 1'b1, 32'h0040_0213, 1'b0, 1'b0, 32'h0,         1'b0, 32'h8000_0104, 1'b1, 32'h0040_0213, 32'h8000_0104};
        vecs[16] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFC, 1'b0, NOP,           32'h0};
        vecs[17] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'hFFFF_FFFC, 1'b0, NOP,           32'h0};
        vecs[18] = '{1'b0, 1'b1, 32'h0050_0293, 1'b0, 1'b0, 32'h0,         1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0050_0293, 32'hFFFF_FFFC};
        vecs[19] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, NOP,           32'h0};

        // Directed table starting from reset release
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].rr, vecs[i].rv, vecs[i].rd, vecs[i].ir, vecs[i].jf, vecs[i].ja);
            checkOutput($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_req));
            checkOutput($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].e_addr);
            checkOutput($sformatf("vec%0d_inst_valid", i), 32'(inst_valid_o), 32'(vecs[i].e_valid));
            checkOutput($sformatf("vec%0d_inst", i), inst_o, vecs[i].e_inst);
            if (vecs[i].e_valid)
                checkOutput($sformatf("vec%0d_inst_addr", i), inst_addr_o, vecs[i].e_iaddr);
        end

        // Request stalled by memory for 5 cycles, then exactly one handshake
        doReset();
        checkResetValues("release");
        idle();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("stall%0d_req_valid", i), 32'(imem_req_valid), 32'd1);
            checkOutput($sformatf("stall%0d_req_addr", i), imem_req_addr, RESET_PC);
            idle();
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("wait%0d_req_valid", i), 32'(imem_req_valid), 32'd0);
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        end
        applyStimulus(1'b1, 1'b1, 32'h0060_0313, 1'b0, 1'b0, 32'h0);
        checkOutput("hold_enter_valid", 32'(inst_valid_o), 32'd1);
        checkOutput("hold_enter_inst", inst_o, 32'h0060_0313);
        held_inst = inst_o;
        held_addr = inst_addr_o;

        // Decode stalls 4 cycles with a stray jump request that must be ignored
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 32'hBAD0_0004, 1'b0, 1'b1, 32'hC000_0000);
            checkOutput($sformatf("hold%0d_inst", i), inst_o, 32'h0060_0313);
            checkOutput($sformatf("hold%0d_inst_addr", i), inst_addr_o, RESET_PC);
            checkOutput($sformatf("hold%0d_valid", i), 32'(inst_valid_o), 32'd1);
            checkOutput($sformatf("hold%0d_req_valid", i), 32'(imem_req_valid), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hC000_0000);
        checkOutput("after_hold_req_addr", imem_req_addr, 32'h8000_0004);
        checkOutput("after_hold_req_valid", 32'(imem_req_valid), 32'd1);

        // Reset pulse while a response is pending
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("pre_rst_wait_req_valid", 32'(imem_req_valid), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        checkResetValues("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetValues("rst_release");
        idle();
        checkOutput("restart_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("restart_req_addr", imem_req_addr, RESET_PC);

        // Randomized run against a transaction-level model
        doReset();
        idle();
        exp_req   = 1'b1;
        exp_valid = 1'b0;
        pend      = 1'b0;
        wcnt      = 0;
        mpc       = RESET_PC;
        exp_inst  = NOP;
        exp_ia    = RESET_PC;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checkOutput("rnd_req_valid", 32'(imem_req_valid), 32'(exp_req));
            if (exp_req)
                checkOutput("rnd_req_addr", imem_req_addr, mpc);
            checkOutput("rnd_inst_valid", 32'(inst_valid_o), 32'(exp_valid));
            checkOutput("rnd_inst", inst_o, exp_valid ? exp_inst : NOP);
            if (exp_valid)
                checkOutput("rnd_inst_addr", inst_addr_o, exp_ia);

            rr = ($urandom_range(0, 3) != 0);
            ir = ($urandom_range(0, 2) == 0);
            jf = 1'($urandom_range(0, 1));
            ja = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
            rv = 1'b0;
            rd = $urandom;
            nreq   = exp_req;
            nvalid = exp_valid;
            if (pend) begin
                if (wcnt == 0) begin
                    rv       = 1'b1;
                    rd       = mem_word(mpc);
                    pend     = 1'b0;
                    nvalid   = 1'b1;
                    exp_inst = rd;
                    exp_ia   = mpc;
                end else begin
                    wcnt--;
                end
            end else begin
                rv = ($urandom_range(0, 3) == 0);
            end
            if (exp_req && rr) begin
                nreq = 1'b0;
                pend = 1'b1;
                wcnt = $urandom_range(0, 2);
            end
            if (exp_valid && ir) begin
                nvalid = 1'b0;
                nreq   = 1'b1;
                mpc    = jf ? (ja & 32'hFFFF_FFFC) : (mpc + 32'd4);
            end
            exp_req   = nreq;
            exp_valid = nvalid;
            applyStimulus(rr, rv, rd, ir, jf, ja);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
